mem_stage: RTL and testbench

- Memory-access stage of the 5-stage MIPS pipeline, directly downstream of EX.
- Registers the EX→MEM bus and consumes the data SRAM read data for the load issued by EX in the previous cycle.
- Extracts and sign/zero-extends byte, half and word loads, and selects between the load result and the ALU result.
- Drives the MEM→WB bus and the MEM→ID forwarding bus.

---
 rtl/mem_stage_pkg.sv | 45 ++++
 rtl/mem_stage_if.sv | 23 ++
 rtl/mem_stage_load_align.sv | 51 +++++
 rtl/mem_stage.sv | 88 ++++++++
 tb/tb_mem_stage.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared widths, stall encoding, load opcodes and bus layouts for the MEM stage.
// Bus structs are packed MSB-first so they match the flat bit layouts on the pipeline buses.
package mem_stage_pkg;

    localparam int unsigned StallBus  = 6;
    localparam int unsigned ExToMemWd = 79;
    localparam int unsigned MemToWbWd = 70;
    localparam int unsigned MemToIdWd = 38;

    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    typedef enum logic [2:0] {
        MemLw  = 3'd0,
        MemLb  = 3'd1,
        MemLbu = 3'd2,
        MemLh  = 3'd3,
        MemLhu = 3'd4
    } mem_op_e;

    typedef struct packed {
        logic [2:0]  mem_op;
        logic [31:0] pc;
        logic        data_ram_en;
        logic [3:0]  data_ram_wen;
        logic        sel_rf_res;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] ex_result;
    } ex_to_mem_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
    } mem_to_wb_t;

    typedef struct packed {
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
    } mem_to_id_t;

endpackage

// File: rtl/mem_stage_if.sv
// Bundle of the buses entering and leaving the MEM stage.
// The slave modport is the stage itself; master is the surrounding pipeline.
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic [StallBus-1:0] stall;
    ex_to_mem_t          ex_to_mem_bus;
    logic [31:0]         data_sram_rdata;
    mem_to_wb_t          mem_to_wb_bus;
    mem_to_id_t          mem_to_id_bus;
    logic                mem_adel;

    modport master (
        output stall, ex_to_mem_bus, data_sram_rdata,
        input  mem_to_wb_bus, mem_to_id_bus, mem_adel
    );

    modport slave (
        input  stall, ex_to_mem_bus, data_sram_rdata,
        output mem_to_wb_bus, mem_to_id_bus, mem_adel
    );

endinterface

// File: rtl/mem_stage_load_align.sv
// Byte/half/word extraction with sign or zero extension, plus alignment check.
// Unknown opcodes behave as LW.
module mem_stage_load_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]  mem_op_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] load_data_o,
    output logic        misalign_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[7:0];
        case (offset_i)
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            2'd3:    byte_sel = rdata_i[31:24];
            default: byte_sel = rdata_i[7:0];
        endcase
        half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    always_comb begin
        load_data_o = rdata_i;
        misalign_o  = (offset_i != 2'b00);
        case (mem_op_i)
            MemLb: begin
                load_data_o = {{24{byte_sel[7]}}, byte_sel};
                misalign_o  = 1'b0;
            end
            MemLbu: begin
                load_data_o = {24'b0, byte_sel};
                misalign_o  = 1'b0;
            end
            MemLh: begin
                load_data_o = {{16{half_sel[15]}}, half_sel};
                misalign_o  = offset_i[0];
            end
            MemLhu: begin
                load_data_o = {16'b0, half_sel};
                misalign_o  = offset_i[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: registers the EX->MEM bus, holds SRAM load data across WB-side stalls,
// aligns/extends loads and drives the MEM->WB and MEM->ID forwarding buses.
module mem_stage
    import mem_stage_pkg::*;
(
    input logic      clk,
    input logic      rst,
    mem_stage_if.slave bus_if
);

    ex_to_mem_t  ex_to_mem_bus_q, ex_to_mem_bus_d;
    logic [31:0] rdata_buf_q, rdata_buf_d;
    logic        rdata_vld_q, rdata_vld_d;

    logic        stall_ex_mem, stall_mem_wb;
    logic        is_load;
    logic [31:0] rdata_sel;
    logic [31:0] load_data;
    logic        misalign;
    logic        adel;
    logic        unused_stall;

    assign stall_ex_mem = bus_if.stall[3];
    assign stall_mem_wb = bus_if.stall[4];
    assign unused_stall = ^{bus_if.stall[5], bus_if.stall[2:0]};

    assign is_load = ex_to_mem_bus_q.data_ram_en & (ex_to_mem_bus_q.data_ram_wen == 4'b0);

    always_comb begin
        ex_to_mem_bus_d = ex_to_mem_bus_q;
        if (stall_ex_mem == Stop && stall_mem_wb == NoStop) begin
            ex_to_mem_bus_d = '0;
        end else if (stall_ex_mem == NoStop) begin
            ex_to_mem_bus_d = bus_if.ex_to_mem_bus;
        end
    end

    // SRAM data is only valid in the first MEM cycle; keep it while WB is stalled.
    always_comb begin
        rdata_buf_d = rdata_buf_q;
        rdata_vld_d = rdata_vld_q;
        if (!(stall_ex_mem == Stop && stall_mem_wb == Stop)) begin
            rdata_vld_d = 1'b0;
        end else if (is_load && !rdata_vld_q) begin
            rdata_vld_d = 1'b1;
            rdata_buf_d = bus_if.data_sram_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_to_mem_bus_q <= '0;
            rdata_buf_q     <= '0;
            rdata_vld_q     <= 1'b0;
        end else begin
            ex_to_mem_bus_q <= ex_to_mem_bus_d;
            rdata_buf_q     <= rdata_buf_d;
            rdata_vld_q     <= rdata_vld_d;
        end
    end

    assign rdata_sel = rdata_vld_q ? rdata_buf_q : bus_if.data_sram_rdata;

    mem_stage_load_align u_load_align (
        .mem_op_i    (ex_to_mem_bus_q.mem_op),
        .offset_i    (ex_to_mem_bus_q.ex_result[1:0]),
        .rdata_i     (rdata_sel),
        .load_data_o (load_data),
        .misalign_o  (misalign)
    );

    assign adel = is_load & misalign;

    always_comb begin
        bus_if.mem_to_wb_bus.pc       = ex_to_mem_bus_q.pc;
        bus_if.mem_to_wb_bus.rf_we    = ex_to_mem_bus_q.rf_we & ~adel;
        bus_if.mem_to_wb_bus.rf_waddr = ex_to_mem_bus_q.rf_waddr;
        bus_if.mem_to_wb_bus.rf_wdata = ex_to_mem_bus_q.ex_result;
        if (!adel && ex_to_mem_bus_q.sel_rf_res && is_load) begin
            bus_if.mem_to_wb_bus.rf_wdata = load_data;
        end
        bus_if.mem_to_id_bus.rf_we    = bus_if.mem_to_wb_bus.rf_we;
        bus_if.mem_to_id_bus.rf_waddr = bus_if.mem_to_wb_bus.rf_waddr;
        bus_if.mem_to_id_bus.rf_wdata = bus_if.mem_to_wb_bus.rf_wdata;
        bus_if.mem_adel               = adel;
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: stimulus pushes hand-computed expectations tagged with the
// cycle they apply to; a negedge monitor pops and compares them against the DUT outputs.
module tb_mem_stage;
    import mem_stage_pkg::*;

    typedef struct {
        string       name;
        int          cyc;
        logic [31:0] pc;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        adel;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_cmp;
    int   n_bad;
    exp_t sb[$];

    mem_stage_if ifc ();

    mem_stage dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic ex_to_mem_t mk(input logic [2:0] op, input logic [31:0] pc,
                                      input logic en, input logic [3:0] wen, input logic sel,
                                      input logic we, input logic [4:0] waddr,
                                      input logic [31:0] res);
        ex_to_mem_t b;
        b.mem_op       = op;
        b.pc           = pc;
        b.data_ram_en  = en;
        b.data_ram_wen = wen;
        b.sel_rf_res   = sel;
        b.rf_we        = we;
        b.rf_waddr     = waddr;
        b.ex_result    = res;
        return b;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_now(input string name, input logic [31:0] pc, input logic we,
                              input logic [4:0] waddr, input logic [31:0] wdata,
                              input logic adel);
        exp_t e;
        e.name  = name;
        e.cyc   = cyc;
        e.pc    = pc;
        e.we    = we;
        e.waddr = waddr;
        e.wdata = wdata;
        e.adel  = adel;
        sb.push_back(e);
    endtask

    task automatic check(input string name, input string field, input logic [69:0] got,
                         input logic [69:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s %s: got %h expected %h", name, field, got, want);
        end
    endtask

    // Monitor: outputs are combinational, so every cycle presents a result.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            exp_t s;
            s = sb.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL %s missed: got no sample at cycle %0d expected one", s.name, s.cyc);
        end
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            exp_t e;
            e = sb.pop_front();
            check(e.name, "mem_to_wb", 70'(ifc.mem_to_wb_bus),
                  {e.pc, e.we, e.waddr, e.wdata});
            check(e.name, "mem_to_id", 70'(ifc.mem_to_id_bus), 70'({e.we, e.waddr, e.wdata}));
            check(e.name, "mem_adel", 70'(ifc.mem_adel), 70'(e.adel));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        ifc.stall = '0;
        ifc.ex_to_mem_bus = '0;
        ifc.data_sram_rdata = '0;

        step();
        expect_now("reset", 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
        step();
        rst = 1'b0;
        ifc.ex_to_mem_bus = mk(MemLw, 32'h400, 1, 4'h0, 1, 1, 5'd8, 32'h100);
        expect_now("reset_hold", 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);

        step();
        ifc.data_sram_rdata = 32'hDEADBEEF;
        expect_now("lw", 32'h400, 1'b1, 5'd8, 32'hDEADBEEF, 1'b0);
        ifc.ex_to_mem_bus = mk(MemLb, 32'h404, 1, 4'h0, 1, 1, 5'd9, 32'h103);

        step();
        ifc.data_sram_rdata = 32'h80FF1234;
        expect_now("lb_off3", 32'h404, 1'b1, 5'd9, 32'hFFFFFF80, 1'b0);
        ifc.ex_to_mem_bus = mk(MemLbu, 32'h408, 1, 4'h0, 1, 1, 5'd10, 32'h103);

        step();
        expect_now("lbu_off3", 32'h408, 1'b1, 5'd10, 32'h00000080, 1'b0);
        ifc.ex_to_mem_bus = mk(MemLh, 32'h40C, 1, 4'h0, 1, 1, 5'd11, 32'h102);

        step();
        ifc.data_sram_rdata = 32'h80017FFF;
        expect_now("lh_off2", 32'h40C, 1'b1, 5'd11, 32'hFFFF8001, 1'b0);
        ifc.ex_to_mem_bus = mk(MemLhu, 32'h410, 1, 4'h0, 1, 1, 5'd12, 32'h100);

        step();
        expect_now("lhu_off0", 32'h410, 1'b1, 5'd12, 32'h00007FFF, 1'b0);
        ifc.ex_to_mem_bus = mk(MemLw, 32'h414, 1, 4'h0, 1, 1, 5'd13, 32'h200);

        // Load stalled three cycles while SRAM data goes away.
        step();
        ifc.data_sram_rdata = 32'h12345678;
        ifc.stall = 6'b011111;
        expect_now("stall_c1", 32'h414, 1'b1, 5'd13, 32'h12345678, 1'b0);
        ifc.ex_to_mem_bus = mk(MemLw, 32'h418, 0, 4'h0, 0, 1, 5'd14, 32'h77);
        step();
        ifc.data_sram_rdata = 32'h0;
        expect_now("stall_c2", 32'h414, 1'b1, 5'd13, 32'h12345678, 1'b0);
        step();
        expect_now("stall_c3", 32'h414, 1'b1, 5'd13, 32'h12345678, 1'b0);
        step();
        ifc.stall = '0;
        expect_now("stall_release", 32'h414, 1'b1, 5'd13, 32'h12345678, 1'b0);

        step();
        expect_now("addu_next", 32'h418, 1'b1, 5'd14, 32'h77, 1'b0);
        ifc.stall = 6'b001111;
        ifc.ex_to_mem_bus = mk(MemLw, 32'h41C, 1, 4'h0, 1, 1, 5'd15, 32'h0);

        step();
        ifc.stall = '0;
        expect_now("bubble", 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
        ifc.ex_to_mem_bus = mk(MemLh, 32'h420, 1, 4'h0, 1, 1, 5'd5, 32'h301);

        step();
        ifc.data_sram_rdata = 32'hAABBCCDD;
        expect_now("lh_adel", 32'h420, 1'b0, 5'd5, 32'h301, 1'b1);
        ifc.ex_to_mem_bus = mk(3'd7, 32'h424, 1, 4'h0, 1, 1, 5'd0, 32'h40);

        step();
        ifc.data_sram_rdata = 32'hCAFEF00D;
        expect_now("unk_op_r0", 32'h424, 1'b1, 5'd0, 32'hCAFEF00D, 1'b0);
        ifc.ex_to_mem_bus = mk(MemLw, 32'h428, 1, 4'hF, 0, 0, 5'd0, 32'h1002);

        step();
        expect_now("store", 32'h428, 1'b0, 5'd0, 32'h1002, 1'b0);
        ifc.ex_to_mem_bus = mk(MemLw, 32'h42C, 0, 4'h0, 0, 1, 5'd3, 32'h55);

        step();
        ifc.data_sram_rdata = 32'hFFFFFFFF;
        expect_now("addu_pass", 32'h42C, 1'b1, 5'd3, 32'h55, 1'b0);
        ifc.ex_to_mem_bus = mk(MemLw, 32'h430, 1, 4'h0, 1, 1, 5'd6, 32'h204);

        // Reset arrives while a buffered load is stalled.
        step();
        ifc.data_sram_rdata = 32'hAAAA5555;
        ifc.stall = 6'b011111;
        expect_now("lw_pre_rst", 32'h430, 1'b1, 5'd6, 32'hAAAA5555, 1'b0);
        step();
        ifc.data_sram_rdata = 32'h0;
        rst = 1'b1;
        expect_now("lw_held", 32'h430, 1'b1, 5'd6, 32'hAAAA5555, 1'b0);
        step();
        rst = 1'b0;
        expect_now("rst_mid_stall", 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
        step();
        ifc.stall = '0;
        expect_now("post_rst_hold", 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
        ifc.ex_to_mem_bus = mk(MemLw, 32'h434, 1, 4'h0, 1, 1, 5'd7, 32'h208);

        step();
        ifc.data_sram_rdata = 32'h0F0F0F0F;
        expect_now("lw_after_rst", 32'h434, 1'b1, 5'd7, 32'h0F0F0F0F, 1'b0);
        ifc.ex_to_mem_bus = '0;

        step();
        expect_now("nop", 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
